// File: rtl/search_crpr_rx_if.sv
// Bundle of the serial capture inputs and the valid/ready word output of
// search_crpr_rx; the slave modport is the receiver's view.
interface search_crpr_rx_if #(
    parameter int WIDTH = 8
);
    logic             sdata;
    logic             sframe;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_perr;
    logic             err_short;
    logic             ovf;
    logic [7:0]       frm_cnt;

    modport slave (
        input  sdata, sframe, out_ready,
        output out_data, out_valid, out_perr, err_short, ovf, frm_cnt
    );

    modport master (
        output sdata, sframe, out_ready,
        input  out_data, out_valid, out_perr, err_short, ovf, frm_cnt
    );
endinterface

// File: rtl/search_crpr_rx.sv
// Serial-to-parallel frame receiver: LSB-first WIDTH-bit words onto a valid/ready register.
// Optional trailing even-parity bit and out_perr flag under `define SEARCH_CRPR_RX_PARITY_EN.
module search_crpr_rx #(
    parameter int WIDTH = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    search_crpr_rx_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef SEARCH_CRPR_RX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DRAIN  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DRAIN  = 2'd3
    } state_t;
`endif

    function automatic logic data_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             err_short_q, err_short_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       frm_cnt_q, frm_cnt_d;
    logic             complete_s;
    logic             load_s;
    logic [WIDTH-1:0] word_s;
    logic [WIDTH-1:0] ins_s;
`ifdef SEARCH_CRPR_RX_PARITY_EN
    logic             par_bit_s;
`endif

    assign ins_s = {{(WIDTH-1){1'b0}}, bus.sdata};

    // Frame FSM: bit assembly, abort detection, word completion strobe
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        complete_s  = 1'b0;
        word_s      = shift_q;
        err_short_d = 1'b0;
`ifdef SEARCH_CRPR_RX_PARITY_EN
        par_bit_s   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.sframe) begin
                    shift_d = ins_s;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bus.sframe) begin
                    shift_d = shift_q | (ins_s << cnt_q);
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LAST_IDX) begin
`ifdef SEARCH_CRPR_RX_PARITY_EN
                        state_d = PARITY;
`else
                        complete_s = 1'b1;
                        word_s     = shift_d;
                        state_d    = DRAIN;
`endif
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    shift_d     = {WIDTH{1'b0}};
                    cnt_d       = {CW{1'b0}};
                    err_short_d = 1'b1;
                    state_d     = IDLE;
                end
            end
`ifdef SEARCH_CRPR_RX_PARITY_EN
            PARITY: begin
                if (bus.sframe) begin
                    complete_s = 1'b1;
                    par_bit_s  = bus.sdata;
                    word_s     = shift_q;
                    state_d    = DRAIN;
                end else begin
                    shift_d     = {WIDTH{1'b0}};
                    cnt_d       = {CW{1'b0}};
                    err_short_d = 1'b1;
                    state_d     = IDLE;
                end
            end
`endif
            DRAIN: begin
                // Surplus bits of an over-long frame are silently skipped
                if (bus.sframe) begin
                    state_d = DRAIN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = DRAIN;
            end
        endcase
    end

    // Output register: load on completion if the slot is free or being consumed
    always_comb begin
        load_s    = complete_s && (!valid_q || bus.out_ready);
        data_d    = data_q;
        perr_d    = perr_q;
        frm_cnt_d = frm_cnt_q;
        ovf_d     = ovf_q | (complete_s & ~load_s);
        if (load_s) begin
            valid_d   = 1'b1;
            data_d    = word_s;
`ifdef SEARCH_CRPR_RX_PARITY_EN
            perr_d    = data_parity(word_s) ^ par_bit_s;
`else
            perr_d    = 1'b0;
`endif
            frm_cnt_d = frm_cnt_q + 8'd1;
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State and output registers with synchronous reset into DRAIN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= DRAIN;
            shift_q     <= {WIDTH{1'b0}};
            cnt_q       <= {CW{1'b0}};
            data_q      <= {WIDTH{1'b0}};
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            err_short_q <= 1'b0;
            ovf_q       <= 1'b0;
            frm_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            err_short_q <= err_short_d;
            ovf_q       <= ovf_d;
            frm_cnt_q   <= frm_cnt_d;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
`ifdef SEARCH_CRPR_RX_PARITY_EN
    assign bus.out_perr  = perr_q;
`else
    assign bus.out_perr  = 1'b0;
`endif
    assign bus.err_short = err_short_q;
    assign bus.ovf       = ovf_q;
    assign bus.frm_cnt   = frm_cnt_q;
endmodule

// File: tb/tb_search_crpr_rx.sv
// Self-checking bench for search_crpr_rx: directed scenarios plus randomized
// frames compared against a frame-level reference model.
module tb_search_crpr_rx;
    localparam int W = 8;
`ifdef SEARCH_CRPR_RX_PARITY_EN
    localparam int NB = W + 1;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int NB = W;
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    search_crpr_rx_if #(.WIDTH(W)) ifc ();

    search_crpr_rx #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    // Reference model of the output register, updated once per clock edge
    logic         m_valid, m_perr, m_ovf, m_err;
    logic [W-1:0] m_data;
    logic [7:0]   m_cnt;
    logic         err_seen, ovf_seen;

    function automatic logic exp_perr(input logic [W-1:0] w, input logic pb);
        return ((^w) ^ pb) & PAR_EN;
    endfunction

    task automatic tick(input logic f, input logic d, input logic r,
                        input bit done, input bit abort,
                        input logic [W-1:0] w, input logic pb);
        @(negedge clk);
        ifc.sframe = f;
        ifc.sdata = d;
        ifc.out_ready = r;
        @(posedge clk);
        if (done) begin
            if (!m_valid || r) begin
                m_valid = 1'b1;
                m_data = w;
                m_perr = exp_perr(w, pb);
                m_cnt = m_cnt + 8'd1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        m_err = abort;
        #1;
        err_seen = err_seen | ifc.err_short;
        ovf_seen = ovf_seen | ifc.ovf;
    endtask

    task automatic do_reset(input logic sf);
        @(negedge clk);
        rst = 1'b1;
        ifc.sframe = sf;
        ifc.sdata = 1'b0;
        ifc.out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b0; m_perr = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
        m_data = '0; m_cnt = 8'd0;
        err_seen = 1'b0; ovf_seen = 1'b0;
    endtask

    // nbits < NB produces an aborted frame; rdy_pct is the out_ready probability
    task automatic send_frame(input logic [W-1:0] w, input logic pb, input int nbits,
                              input int gap, input int rdy_pct);
        logic r;
        logic d;
        for (int i = 0; i < nbits; i++) begin
            r = ($urandom_range(99) < rdy_pct);
            d = (i < W) ? w[i] : pb;
            tick(1'b1, d, r, (nbits == NB) && (i == NB - 1), 1'b0, w, pb);
        end
        if (nbits > 0 && nbits < NB) begin
            r = ($urandom_range(99) < rdy_pct);
            tick(1'b0, 1'b0, r, 1'b0, 1'b1, w, pb);
        end
        for (int g = 0; g < gap; g++) begin
            r = ($urandom_range(99) < rdy_pct);
            tick(1'b0, 1'b0, r, 1'b0, 1'b0, w, pb);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", ifc.out_valid); end
        total++; if (ifc.out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", ifc.out_data); end
        total++; if (ifc.frm_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", ifc.frm_cnt); end
        total++; if ({ifc.ovf, ifc.err_short, ifc.out_perr} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {ifc.ovf, ifc.err_short, ifc.out_perr}); end
    endtask

    task automatic test_basic();
        do_reset(1'b0);
        send_frame(8'hA5, 1'b0, NB, 0, 100);
        total++; if (ifc.out_data !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h want=a5", ifc.out_data); end
        total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", ifc.out_valid); end
        total++; if (ifc.frm_cnt !== 8'd1) begin bad++; $display("FAIL basic_cnt got=%0d want=1", ifc.frm_cnt); end
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL basic_consume got=%b want=0", ifc.out_valid); end
    endtask

    task automatic test_abort();
        do_reset(1'b0);
        send_frame(8'h55, 1'b0, 3, 0, 100);
        total++; if (ifc.err_short !== 1'b1) begin bad++; $display("FAIL abort_pulse got=%b want=1", ifc.err_short); end
        total++; if (ifc.out_valid !== 1'b0 || ifc.frm_cnt !== 8'd0) begin bad++; $display("FAIL abort_noword valid=%b cnt=%0d want 0/0", ifc.out_valid, ifc.frm_cnt); end
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        total++; if (ifc.err_short !== 1'b0) begin bad++; $display("FAIL abort_pulse_end got=%b want=0", ifc.err_short); end
        send_frame(8'h3C, 1'b0, NB, 0, 100);
        total++; if (ifc.out_data !== 8'h3C || ifc.out_valid !== 1'b1 || ifc.frm_cnt !== 8'd1) begin bad++; $display("FAIL abort_next got=%h/%b/%0d want=3c/1/1", ifc.out_data, ifc.out_valid, ifc.frm_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        send_frame(8'h11, 1'b0, NB, 1, 0);
        send_frame(8'h22, 1'b0, NB, 0, 0);
        total++; if (ifc.out_data !== 8'h11) begin bad++; $display("FAIL b2b_data got=%h want=11", ifc.out_data); end
        total++; if (ifc.ovf !== 1'b1 || ifc.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_ovf ovf=%b valid=%b want 1/1", ifc.ovf, ifc.out_valid); end
        total++; if (ifc.frm_cnt !== 8'd1) begin bad++; $display("FAIL b2b_cnt got=%0d want=1", ifc.frm_cnt); end
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        total++; if (ifc.out_valid !== 1'b0 || ifc.ovf !== 1'b1) begin bad++; $display("FAIL b2b_drain valid=%b ovf=%b want 0/1", ifc.out_valid, ifc.ovf); end
    endtask

    task automatic test_reset_midframe();
        do_reset(1'b1);
        for (int i = 0; i < 12; i++) tick(1'b1, 1'($urandom_range(1)), 1'b1, 1'b0, 1'b0, '0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        total++; if (ifc.out_valid !== 1'b0 || ifc.frm_cnt !== 8'd0) begin bad++; $display("FAIL midrst_ignored valid=%b cnt=%0d want 0/0", ifc.out_valid, ifc.frm_cnt); end
        send_frame(8'hF0, 1'b0, NB, 0, 100);
        total++; if (ifc.out_data !== 8'hF0 || ifc.frm_cnt !== 8'd1) begin bad++; $display("FAIL midrst_word got=%h/%0d want=f0/1", ifc.out_data, ifc.frm_cnt); end
        total++; if (err_seen !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b want=0", err_seen); end
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        logic pb;
        int nb;
        do_reset(1'b0);
        for (int f = 0; f < 60; f++) begin
            w = W'($urandom);
            pb = 1'($urandom_range(1));
            nb = ($urandom_range(5) == 0) ? int'($urandom_range(NB - 1, 1)) : NB;
            send_frame(w, pb, nb, int'($urandom_range(3, 1)), 70);
            total++; if (ifc.out_valid !== m_valid) begin bad++; $display("FAIL rnd_valid f=%0d got=%b want=%b", f, ifc.out_valid, m_valid); end
            total++; if (ifc.out_data !== m_data) begin bad++; $display("FAIL rnd_data f=%0d got=%h want=%h", f, ifc.out_data, m_data); end
            total++; if (ifc.frm_cnt !== m_cnt) begin bad++; $display("FAIL rnd_cnt f=%0d got=%0d want=%0d", f, ifc.frm_cnt, m_cnt); end
            total++; if (ifc.ovf !== m_ovf || ifc.out_perr !== m_perr || ifc.err_short !== m_err) begin bad++; $display("FAIL rnd_flags f=%0d got=%b%b%b want=%b%b%b", f, ifc.ovf, ifc.out_perr, ifc.err_short, m_ovf, m_perr, m_err); end
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b0);
        for (int f = 0; f < 256; f++) send_frame(W'($urandom), 1'b0, NB, 1, 100);
        total++; if (ifc.frm_cnt !== 8'd0) begin bad++; $display("FAIL wrap_cnt got=%0d want=0", ifc.frm_cnt); end
        total++; if (ovf_seen !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%b want=0", ovf_seen); end
        total++; if (ifc.out_data !== m_data) begin bad++; $display("FAIL wrap_data got=%h want=%h", ifc.out_data, m_data); end
    endtask

`ifdef SEARCH_CRPR_RX_PARITY_EN
    task automatic test_parity();
        do_reset(1'b0);
        send_frame(8'h07, 1'b1, NB, 0, 100);
        total++; if (ifc.out_perr !== 1'b0 || ifc.out_valid !== 1'b1) begin bad++; $display("FAIL par_good perr=%b valid=%b want 0/1", ifc.out_perr, ifc.out_valid); end
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        send_frame(8'h07, 1'b0, NB, 0, 100);
        total++; if (ifc.out_perr !== 1'b1 || ifc.out_data !== 8'h07 || ifc.frm_cnt !== 8'd2) begin bad++; $display("FAIL par_bad perr=%b data=%h cnt=%0d want 1/07/2", ifc.out_perr, ifc.out_data, ifc.frm_cnt); end
    endtask
`endif

    initial begin
        ifc.sframe = 1'b0;
        ifc.sdata = 1'b0;
        ifc.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_abort();
        test_back_to_back();
        test_reset_midframe();
`ifdef SEARCH_CRPR_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/search_crpr_rx.md
# search_crpr_rx

Serial-to-parallel frame receiver: samples a 1-bit serial stream qualified by a frame strobe, assembles WIDTH-bit words LSB-first, and presents each word on a valid/ready output register. It is the capture end of the launch-side serial pipeline in the search CRPR test designs. All state shares one clock root, so every receive-path register pair is a CRPR candidate for the timer.

## Interface
- WIDTH, 8: data bits per frame; legal range 2..16.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sdata  input  1  serial data bit; sampled only while sframe=1.
- sframe  input  1  frame strobe; high for exactly one frame length, then low for ≥1 cycle.
- out_data  output  WIDTH  received word; held stable while out_valid=1.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid=1 in the same cycle.
- out_perr  output  1  parity error flag for out_data; constant 0 without the macro.
- err_short  output  1  one-cycle pulse: frame aborted before its final bit.
- ovf  output  1  sticky: a completed word was dropped because the output was full.
- frm_cnt  output  8  count of words loaded into out_data; wraps 255→0.

## Operation
- FSM states: IDLE, SHIFT, PARITY (macro only), DRAIN.
- The reset state is DRAIN, so a frame already in progress when reset releases is ignored.
- IDLE:
  - sframe=1: store sdata in bit 0, set bit counter to 1, go to SHIFT.
- SHIFT:
  - sframe=1: store sdata at the counter position and increment the counter.
  - When bit WIDTH-1 is stored: go to PARITY with the macro; otherwise complete the word and go to DRAIN.
  - sframe=0: discard the partial word, pulse err_short, go to IDLE.
- PARITY:
  - sframe=1: sample the parity bit, complete the word, go to DRAIN.
  - sframe=0: abort exactly as in SHIFT.
- DRAIN:
  - While sframe=1, extra bits are ignored and nothing is flagged.
  - sframe=0: go to IDLE.
  - A frame therefore needs ≥1 low cycle before the next frame starts.
- Word completion:
  - If out_valid=0, or out_valid=1 with out_ready=1 in that cycle: load out_data and out_perr, set out_valid=1, increment frm_cnt.
  - Otherwise: drop the word and set ovf=1. ovf clears only on rst.
- Output handshake:
  - out_valid clears after an edge where out_valid=1, out_ready=1 and no word completes.
  - out_data changes only on a load.

## Timing
- Reset values: out_data=0, out_valid=0, out_perr=0, err_short=0, ovf=0, frm_cnt=0, state=DRAIN, shift register and counter 0.
- rst mid-frame discards the partial word with no err_short pulse. rst takes priority over every other event.
- Latency: the final bit (data or parity) is sampled at edge N, and out_valid=1 is visible after edge N. Minimum frame-to-word latency is WIDTH (or WIDTH+1) cycles from the first sampled bit.
- Peak throughput: one word per WIDTH+1 cycles (WIDTH+2 with parity).
- err_short rises at the edge that detects the abort and clears at the next edge.
- A completion coinciding with an out_ready handshake loads the new word. out_valid stays 1 and no ovf is raised.
- frm_cnt arithmetic is modulo 256.

## Configuration
- SEARCH_CRPR_RX_PARITY_EN defined:
  - Each frame is WIDTH+1 bits; the last bit is even parity over the data.
  - out_perr is loaded with (XOR of data bits) XOR (parity bit).
  - The word is delivered even when out_perr=1.
- Undefined:
  - Frames are WIDTH bits, the PARITY state does not exist, and out_perr is tied to 0.

## Test plan
- WIDTH=8, no macro, out_ready=1: frame bits LSB-first 1,0,1,0,0,1,0,1 → out_data=8'hA5 and out_valid=1 after the 8th sampled edge; frm_cnt=1.
- sframe drops after 3 bits → err_short is high for one cycle, out_valid stays 0, frm_cnt=0; the next full frame 8'h3C is delivered correctly.
- out_ready=0 with two back-to-back frames 8'h11 then 8'h22 → out_data stays 8'h11 and ovf=1. Raising out_ready → out_valid drops the next cycle and ovf stays 1.
- sframe already high when rst deasserts, held 12 cycles, then 1 cycle low, then frame 8'hF0 → only 8'hF0 is delivered; frm_cnt=1; no err_short.
- Macro defined: data 8'h07 with parity 1 → out_perr=0; data 8'h07 with parity 0 → out_perr=1, word still delivered.
- 256 frames with out_ready=1 → frm_cnt wraps to 0 and ovf=0 throughout.
